alu_seq: RTL and testbench

Multi-cycle execute sequencer sitting directly upstream and downstream of the 4-entry register file. It accepts one instruction at a time over a valid/ready handshake, drives the register file's read ports, computes an ALU result on the returned operands, and writes the result back through the register file's write port. It is the datapath controller that turns opcode/register-index instructions into the register file's read-enable, read-address, write-enable and write-data strobes.

---
 rtl/alu_seq_pkg.sv | 20 ++
 rtl/alu_seq_if.sv | 24 ++
 rtl/alu_core.sv | 44 ++++
 rtl/alu_seq.sv | 135 +++++++++++++
 tb/tb_alu_seq.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcode and state encodings for the alu_seq execute sequencer.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_OR    = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_NOT   = 3'd5;
  localparam logic [2:0] OP_LOADI = 3'd6;
  localparam logic [2:0] OP_MOV   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Instruction valid/ready handshake between an issuer (master) and alu_seq (slave).
interface alu_seq_if #(
  parameter int unsigned REGISTER_LEN = 10
);

  logic                    InstrValid;
  logic                    InstrReady;
  logic [2:0]              Opcode;
  logic [1:0]              Dst;
  logic [1:0]              SrcA;
  logic [1:0]              SrcB;
  logic [REGISTER_LEN-1:0] Imm;

  modport master (
    output InstrValid, Opcode, Dst, SrcA, SrcB, Imm,
    input  InstrReady
  );

  modport slave (
    input  InstrValid, Opcode, Dst, SrcA, SrcB, Imm,
    output InstrReady
  );

endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU for alu_seq: result modulo 2^REGISTER_LEN plus carry/borrow.
module alu_core
  import alu_seq_pkg::*;
#(
  parameter int unsigned REGISTER_LEN = 10
) (
  input  logic [2:0]              Opcode,
  input  logic [REGISTER_LEN-1:0] A,
  input  logic [REGISTER_LEN-1:0] B,
  input  logic [REGISTER_LEN-1:0] Imm,
  output logic [REGISTER_LEN-1:0] result,
  output logic                    carry
);

  logic [REGISTER_LEN:0] sum;
  logic [REGISTER_LEN:0] diff;

  // Extra top bit of diff is the borrow (set iff A < B unsigned).
  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = {1'b0, A} - {1'b0, B};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (Opcode)
      OP_ADD: begin
        result = sum[REGISTER_LEN-1:0];
        carry  = sum[REGISTER_LEN];
      end
      OP_SUB: begin
        result = diff[REGISTER_LEN-1:0];
        carry  = diff[REGISTER_LEN];
      end
      OP_AND:   result = A & B;
      OP_OR:    result = A | B;
      OP_XOR:   result = A ^ B;
      OP_NOT:   result = ~A;
      OP_LOADI: result = Imm;
      OP_MOV:   result = A;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle execute sequencer driving a 4-entry register file (IDLE/READ/EXEC/WRITE).
// Zero/Carry flag registers exist only when ALU_FLAGS_EN is defined.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned REGISTER_LEN = 10
) (
  input  logic                    Clock,
  input  logic                    Reset,
  alu_seq_if.slave                instr,
  output logic                    RAE,
  output logic                    RBE,
  output logic [1:0]              RAA,
  output logic [1:0]              RBA,
  input  logic [REGISTER_LEN-1:0] A,
  input  logic [REGISTER_LEN-1:0] B,
  output logic                    WE,
  output logic [1:0]              WA,
  output logic [REGISTER_LEN-1:0] RFIN,
  output logic                    Done,
  output logic                    Zero,
  output logic                    Carry
);

  state_t                  state_q, state_d;
  logic                    ready;
  logic                    accept;
  logic [2:0]              op_q;
  logic [1:0]              dst_q;
  logic [REGISTER_LEN-1:0] imm_q;
  logic [1:0]              raa_q, rba_q, wa_q;
  logic [REGISTER_LEN-1:0] result_q;
  logic [REGISTER_LEN-1:0] alu_result;
  logic                    alu_carry;

  assign ready            = (state_q == S_IDLE) || (state_q == S_WRITE);
  assign accept           = instr.InstrValid & ready;
  assign instr.InstrReady = ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_WRITE: begin
        if (accept) begin
          state_d = (instr.Opcode == OP_LOADI) ? S_EXEC : S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WRITE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Read addresses only move for instructions that actually read, so they hold otherwise.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      op_q  <= OP_ADD;
      dst_q <= '0;
      imm_q <= '0;
      raa_q <= '0;
      rba_q <= '0;
    end else if (accept) begin
      op_q  <= instr.Opcode;
      dst_q <= instr.Dst;
      imm_q <= instr.Imm;
      if (instr.Opcode != OP_LOADI) begin
        raa_q <= instr.SrcA;
        rba_q <= instr.SrcB;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      result_q <= '0;
      wa_q     <= '0;
    end else if (state_q == S_EXEC) begin
      result_q <= alu_result;
      wa_q     <= dst_q;
    end
  end

  alu_core #(
    .REGISTER_LEN(REGISTER_LEN)
  ) u_alu_core (
    .Opcode(op_q),
    .A     (A),
    .B     (B),
    .Imm   (imm_q),
    .result(alu_result),
    .carry (alu_carry)
  );

  assign RAE  = (state_q == S_READ);
  assign RBE  = (state_q == S_READ);
  assign WE   = (state_q == S_WRITE);
  assign Done = (state_q == S_WRITE);
  assign RAA  = raa_q;
  assign RBA  = rba_q;
  assign WA   = wa_q;
  assign RFIN = result_q;

`ifdef ALU_FLAGS_EN
  logic zero_q, carry_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else if (state_q == S_EXEC) begin
      zero_q  <= (alu_result == '0);
      carry_q <= alu_carry;
    end
  end

  assign Zero  = zero_q;
  assign Carry = carry_q;
`else
  logic unused_carry;
  assign unused_carry = alu_carry;
  assign Zero         = 1'b0;
  assign Carry        = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq with a behavioural 4-entry register file.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int unsigned W = 10;
`ifdef ALU_FLAGS_EN
  localparam bit FlagsOn = 1'b1;
`else
  localparam bit FlagsOn = 1'b0;
`endif

  logic         Clock;
  logic         Reset;
  logic         RAE, RBE, WE, Done, Zero, Carry;
  logic [1:0]   RAA, RBA, WA;
  logic [W-1:0] A, B, RFIN;
  logic [W-1:0] rf [0:3];

  int n_checks;
  int n_fail;

  alu_seq_if #(.REGISTER_LEN(W)) instr ();

  alu_seq #(
    .REGISTER_LEN(W)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .instr(instr.slave),
    .RAE  (RAE),
    .RBE  (RBE),
    .RAA  (RAA),
    .RBA  (RBA),
    .A    (A),
    .B    (B),
    .WE   (WE),
    .WA   (WA),
    .RFIN (RFIN),
    .Done (Done),
    .Zero (Zero),
    .Carry(Carry)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Register file: registered read data, write commits at the clock edge.
  always @(posedge Clock) begin
    if (RAE) A <= rf[RAA];
    if (RBE) B <= rf[RBA];
    if (WE) rf[WA] <= RFIN;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_instr(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                           input logic [1:0] sb, input logic [W-1:0] imm,
                           input logic [W-1:0] exp_res, input bit exp_c, input string tag);
    int n;
    bit seen;
    @(negedge Clock);
    chk({tag, " ready"}, 32'(instr.InstrReady), 1);
    instr.InstrValid = 1'b1;
    instr.Opcode     = op;
    instr.Dst        = dst;
    instr.SrcA       = sa;
    instr.SrcB       = sb;
    instr.Imm        = imm;
    @(negedge Clock);
    // Inputs must be ignored once accepted.
    instr.InstrValid = 1'b0;
    instr.Opcode     = ~op;
    instr.Dst        = ~dst;
    instr.SrcA       = ~sa;
    instr.SrcB       = ~sb;
    instr.Imm        = ~imm;
    n    = 1;
    seen = 1'b0;
    while (!seen && n <= 5) begin
      if (op != OP_LOADI && n == 1) begin
        chk({tag, " RAE"}, 32'(RAE), 1);
        chk({tag, " RAA"}, 32'(RAA), 32'(sa));
        chk({tag, " RBA"}, 32'(RBA), 32'(sb));
      end
      if (WE) begin
        seen = 1'b1;
        chk({tag, " latency"}, n, (op == OP_LOADI) ? 2 : 3);
        chk({tag, " WA"}, 32'(WA), 32'(dst));
        chk({tag, " RFIN"}, 32'(RFIN), 32'(exp_res));
        chk({tag, " Done"}, 32'(Done), 1);
        chk({tag, " Zero"}, 32'(Zero), 32'(FlagsOn & (exp_res == '0)));
        chk({tag, " Carry"}, 32'(Carry), 32'(FlagsOn & exp_c));
      end else begin
        n++;
        @(negedge Clock);
      end
    end
    chk({tag, " writeback_seen"}, 32'(seen), 1);
    @(negedge Clock);
    chk({tag, " WE_after"}, 32'(WE), 0);
    chk({tag, " Done_after"}, 32'(Done), 0);
  endtask

  initial begin
    int           acc, wc, pend;
    int           wcyc [3];
    logic [W-1:0] wval [3];
    bit           we_seen;

    n_checks         = 0;
    n_fail           = 0;
    Reset            = 1'b1;
    instr.InstrValid = 1'b0;
    instr.Opcode     = '0;
    instr.Dst        = '0;
    instr.SrcA       = '0;
    instr.SrcB       = '0;
    instr.Imm        = '0;

    // Reset state
    @(negedge Clock);
    @(negedge Clock);
    chk("rst InstrReady", 32'(instr.InstrReady), 1);
    chk("rst WE", 32'(WE), 0);
    chk("rst RAE", 32'(RAE), 0);
    chk("rst Done", 32'(Done), 0);
    chk("rst RFIN", 32'(RFIN), 0);
    chk("rst WA", 32'(WA), 0);
    chk("rst Zero", 32'(Zero), 0);
    chk("rst Carry", 32'(Carry), 0);
    Reset = 1'b0;

    // Basic add
    run_instr(OP_LOADI, 2'd1, 2'd0, 2'd0, 10'd5, 10'd5, 1'b0, "ldi r1=5");
    run_instr(OP_LOADI, 2'd2, 2'd0, 2'd0, 10'd3, 10'd3, 1'b0, "ldi r2=3");
    run_instr(OP_ADD, 2'd0, 2'd1, 2'd2, 10'd0, 10'd8, 1'b0, "add r0");
    chk("rf r0", 32'(rf[0]), 8);

    // Carry out and no-borrow subtract
    run_instr(OP_LOADI, 2'd1, 2'd0, 2'd0, 10'd1000, 10'd1000, 1'b0, "ldi r1=1000");
    run_instr(OP_LOADI, 2'd2, 2'd0, 2'd0, 10'd100, 10'd100, 1'b0, "ldi r2=100");
    run_instr(OP_ADD, 2'd3, 2'd1, 2'd2, 10'd0, 10'd76, 1'b1, "add wrap");
    run_instr(OP_SUB, 2'd3, 2'd1, 2'd2, 10'd0, 10'd900, 1'b0, "sub 900");

    // Borrow and zero result
    run_instr(OP_LOADI, 2'd1, 2'd0, 2'd0, 10'd3, 10'd3, 1'b0, "ldi r1=3");
    run_instr(OP_LOADI, 2'd2, 2'd0, 2'd0, 10'd5, 10'd5, 1'b0, "ldi r2=5");
    run_instr(OP_SUB, 2'd3, 2'd1, 2'd2, 10'd0, 10'd1022, 1'b1, "sub borrow");
    run_instr(OP_SUB, 2'd3, 2'd1, 2'd1, 10'd0, 10'd0, 1'b0, "sub zero");

    // A few logic ops on r1=3, r2=5
    run_instr(OP_XOR, 2'd3, 2'd1, 2'd2, 10'd0, 10'd6, 1'b0, "xor");
    run_instr(OP_NOT, 2'd3, 2'd1, 2'd2, 10'd0, 10'd1020, 1'b0, "not");

    // Back-to-back dependent ADD r1=r1+r1 with InstrValid held high
    run_instr(OP_LOADI, 2'd1, 2'd0, 2'd0, 10'd1, 10'd1, 1'b0, "ldi r1=1");
    @(negedge Clock);
    instr.InstrValid = 1'b1;
    instr.Opcode     = OP_ADD;
    instr.Dst        = 2'd1;
    instr.SrcA       = 2'd1;
    instr.SrcB       = 2'd1;
    acc  = 0;
    wc   = 0;
    pend = 0;
    for (int i = 0; i < 20 && wc < 3; i++) begin
      if (i > 0) @(negedge Clock);
      if (pend != 0) begin
        instr.InstrValid = 1'b0;
        pend = 0;
      end
      if (WE) begin
        wval[wc] = RFIN;
        wcyc[wc] = i;
        wc++;
      end
      if (instr.InstrValid && instr.InstrReady) begin
        acc++;
        if (acc == 3) pend = 1;
      end
    end
    chk("b2b writes", wc, 3);
    chk("b2b accepts", acc, 3);
    chk("b2b val0", 32'(wval[0]), 2);
    chk("b2b val1", 32'(wval[1]), 4);
    chk("b2b val2", 32'(wval[2]), 8);
    chk("b2b spacing01", wcyc[1] - wcyc[0], 3);
    chk("b2b spacing12", wcyc[2] - wcyc[1], 3);
    @(negedge Clock);
    chk("b2b idle WE", 32'(WE), 0);
    chk("rf r1", 32'(rf[1]), 8);

    // Reset during EXEC of ADD r0 drops the instruction
    @(negedge Clock);
    instr.InstrValid = 1'b1;
    instr.Opcode     = OP_ADD;
    instr.Dst        = 2'd0;
    instr.SrcA       = 2'd1;
    instr.SrcB       = 2'd2;
    @(negedge Clock);
    instr.InstrValid = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    chk("mid-rst InstrReady", 32'(instr.InstrReady), 1);
    chk("mid-rst WE", 32'(WE), 0);
    chk("mid-rst RAE", 32'(RAE), 0);
    chk("mid-rst RBE", 32'(RBE), 0);
    chk("mid-rst Done", 32'(Done), 0);
    chk("mid-rst RAA", 32'(RAA), 0);
    chk("mid-rst RBA", 32'(RBA), 0);
    chk("mid-rst WA", 32'(WA), 0);
    chk("mid-rst RFIN", 32'(RFIN), 0);
    chk("mid-rst Zero", 32'(Zero), 0);
    chk("mid-rst Carry", 32'(Carry), 0);
    @(negedge Clock);
    Reset   = 1'b0;
    we_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      if (WE) we_seen = 1'b1;
    end
    chk("mid-rst no WE", 32'(we_seen), 0);
    chk("mid-rst r0 kept", 32'(rf[0]), 8);
    chk("post-rst ready", 32'(instr.InstrReady), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
